spi_frame_ctrl: RTL

Capture controller for the 4-line SPI pixel receiver. It frames the receiver's pixel stream using chip select and converts pixels into frame-buffer write transactions (address, data, write enable). It supports one-shot and continuous capture, reports frame completion, short frames and overrun, and resets the receiver to realign nibble phase. It sits between the SPI receiver and the BRAM frame buffer in the video path.

---
 rtl/spi_frame_ctrl_pkg.sv | 25 ++
 rtl/spi_frame_ctrl_cs_edge_sync.sv | 55 +++++
 rtl/spi_frame_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/spi_frame_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_frame_ctrl_pkg
// Purpose  : Shared video constants and capture-FSM state encoding for the
//            SPI pixel capture path.
// Contents : H_RES, V_RES, FRAME_PIXELS default geometry; state_t and the
//            ST_IDLE / ST_ARMED / ST_CAPTURE state constants.
// Revision : 1.0 - initial release
// ============================================================================
package spi_frame_ctrl_pkg;

    // Default sensor geometry (QVGA).
    localparam int H_RES        = 320;
    localparam int V_RES        = 240;
    localparam int FRAME_PIXELS = H_RES * V_RES;

    // Capture FSM encoding (IDLE, ARMED, CAPTURE).
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_ARMED   = 2'd1;
    localparam state_t ST_CAPTURE = 2'd2;

endpackage : spi_frame_ctrl_pkg
`default_nettype wire

// File: rtl/spi_frame_ctrl_cs_edge_sync.sv
`default_nettype none
// ============================================================================
// Module   : spi_frame_ctrl_cs_edge_sync
// Purpose  : Brings the peripheral's asynchronous active-low chip select into
//            the clk_in domain and derives level and edge strobes from it.
// Ports    : clk_in      - system clock
//            rst_in      - asynchronous active-low reset
//            cs_n_in     - raw chip select, active-low, asynchronous
//            cs_low_out  - synchronised CS is asserted (low)
//            cs_fall_out - one-cycle pulse, CS became active
//            cs_rise_out - one-cycle pulse, CS became inactive
// Revision : 1.0 - initial release
// ============================================================================
module spi_frame_ctrl_cs_edge_sync
(
    input  logic clk_in,
    input  logic rst_in,
    input  logic cs_n_in,
    output logic cs_low_out,
    output logic cs_fall_out,
    output logic cs_rise_out
);

    import spi_frame_ctrl_pkg::*;

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic hist_q,  hist_d;

    always_comb begin
        sync1_d = cs_n_in;
        sync2_d = sync1_q;
        hist_d  = sync2_q;
    end

    // All three stages reset to 1 so that no spurious edge is reported when
    // reset releases with CS idle.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
        end
    end

    assign cs_low_out  = ~sync2_q;
    assign cs_fall_out =  hist_q & ~sync2_q;
    assign cs_rise_out = ~hist_q &  sync2_q;

endmodule : spi_frame_ctrl_cs_edge_sync
`default_nettype wire

// File: rtl/spi_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_frame_ctrl
// Purpose  : Frames the SPI receiver's pixel stream with chip select and turns
//            each pixel into a frame-buffer write. One-shot or continuous
//            capture, frame-done / short-frame / overrun reporting, and a
//            receiver reset pulse to realign nibble phase.
// Ports    : clk_in, rst_in (async active-low)
//            start_in, continuous_in, abort_in      - capture control
//            pixel_in, pixel_valid_in, chip_sel_in  - receiver side
//            rx_rst_out                             - receiver realign pulse
//            addr_out, data_out, we_out             - frame-buffer write port
//            busy_out, frame_done_out, short_frame_out, overrun_out,
//            frame_count_out                        - status
// Revision : 1.0 - initial release
// ============================================================================
module spi_frame_ctrl
#(
    parameter  int DATA_WIDTH   = 8,
    parameter  int H_RES        = spi_frame_ctrl_pkg::H_RES,
    parameter  int V_RES        = spi_frame_ctrl_pkg::V_RES,
    localparam int FRAME_PIXELS = H_RES * V_RES,
    localparam int ADDR_WIDTH   = $clog2(FRAME_PIXELS)
)
(
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    input  logic                  continuous_in,
    input  logic                  abort_in,
    input  logic [DATA_WIDTH-1:0] pixel_in,
    input  logic                  pixel_valid_in,
    input  logic                  chip_sel_in,
    output logic                  rx_rst_out,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  we_out,
    output logic                  busy_out,
    output logic                  frame_done_out,
    output logic                  short_frame_out,
    output logic                  overrun_out,
    output logic [15:0]           frame_count_out
);

    import spi_frame_ctrl_pkg::*;

    // The counter must be able to hold FRAME_PIXELS itself (the "frame full"
    // value), which needs one more code than the address range.
    localparam int                    CNT_WIDTH   = $clog2(FRAME_PIXELS + 1);
    localparam logic [CNT_WIDTH-1:0] c_frame_cnt = CNT_WIDTH'(FRAME_PIXELS);

    logic w_cs_low;
    logic w_cs_fall;
    logic w_cs_rise;

    spi_frame_ctrl_cs_edge_sync u_cs_edge_sync (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .cs_n_in     (chip_sel_in),
        .cs_low_out  (w_cs_low),
        .cs_fall_out (w_cs_fall),
        .cs_rise_out (w_cs_rise)
    );

    state_t                  state_q,       state_d;
    logic [CNT_WIDTH-1:0]    cnt_q,         cnt_d;
    logic                    we_q,          we_d;
    logic [ADDR_WIDTH-1:0]   addr_q,        addr_d;
    logic [DATA_WIDTH-1:0]   data_q,        data_d;
    logic                    rx_rst_q,      rx_rst_d;
    logic                    frame_done_q,  frame_done_d;
    logic                    short_q,       short_d;
    logic                    overrun_q,     overrun_d;
    logic [15:0]             frame_count_q, frame_count_d;

    // A strobe only belongs to the frame while the synchronised CS is low,
    // or on the cycle its rising edge is reported (pixels racing the edge
    // through the synchroniser are still part of the frame).
    logic w_in_window;
    assign w_in_window = w_cs_low | w_cs_rise;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        we_d          = 1'b0;
        addr_d        = addr_q;
        data_d        = data_q;
        rx_rst_d      = 1'b0;
        frame_done_d  = 1'b0;
        short_d       = short_q;
        overrun_d     = overrun_q;
        frame_count_d = frame_count_q;

        if (abort_in) begin
            // Abort wins over start and CS events; the frame is dropped.
            state_d  = ST_IDLE;
            rx_rst_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_in) begin
                        state_d   = ST_ARMED;
                        rx_rst_d  = 1'b1;
                        short_d   = 1'b0;
                        overrun_d = 1'b0;
                    end
                end

                ST_ARMED: begin
                    // Only a fresh falling edge starts a frame, so arming while
                    // CS is already low skips the frame in progress.
                    if (w_cs_fall) begin
                        state_d = ST_CAPTURE;
                        cnt_d   = '0;
                    end
                end

                ST_CAPTURE: begin
                    if (pixel_valid_in && w_in_window) begin
                        if (cnt_q < c_frame_cnt) begin
                            we_d   = 1'b1;
                            addr_d = cnt_q[ADDR_WIDTH-1:0];
                            data_d = pixel_in;
                            cnt_d  = cnt_q + 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end

                    // End-of-frame test uses the count including any pixel
                    // accepted in this same cycle.
                    if (w_cs_rise) begin
                        if (cnt_d == c_frame_cnt) begin
                            frame_done_d  = 1'b1;
                            frame_count_d = frame_count_q + 16'd1;
                        end else begin
                            short_d  = 1'b1;
                            rx_rst_d = 1'b1;
                        end
                        if (continuous_in) begin
                            // Re-arming realigns the receiver like a start.
                            state_d  = ST_ARMED;
                            rx_rst_d = 1'b1;
                        end else begin
                            state_d  = ST_IDLE;
                        end
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            rx_rst_q      <= 1'b0;
            frame_done_q  <= 1'b0;
            short_q       <= 1'b0;
            overrun_q     <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            rx_rst_q      <= rx_rst_d;
            frame_done_q  <= frame_done_d;
            short_q       <= short_d;
            overrun_q     <= overrun_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign rx_rst_out      = rx_rst_q;
    assign addr_out        = addr_q;
    assign data_out        = data_q;
    assign we_out          = we_q;
    assign busy_out        = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
    assign frame_done_out  = frame_done_q;
    assign short_frame_out = short_q;
    assign overrun_out     = overrun_q;
    assign frame_count_out = frame_count_q;

endmodule : spi_frame_ctrl
`default_nettype wire
